// File: rtl/branch_tracker_if.sv
// Dispatch/execute handshake bundle for the speculative branch tracker.
// Master is the pipeline side (dispatch + execute); slave is the tracker.
interface branch_tracker_if #(
    parameter int unsigned NUM_BR      = 4,
    parameter int unsigned ROB_TAG_LEN = 5,
    parameter int unsigned ID_W        = $clog2(NUM_BR)
);
    logic                   alloc_valid;
    logic [ROB_TAG_LEN-1:0] alloc_rob_tag;
    logic                   alloc_ready;
    logic [ID_W-1:0]        alloc_id;
    logic [NUM_BR-1:0]      dep_mask;

    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic                   res_mispredict;

    logic                   resolve;
    logic [NUM_BR-1:0]      resolve_mask;
    logic                   kill;
    logic [NUM_BR-1:0]      kill_mask;
    logic [ROB_TAG_LEN-1:0] kill_rob_tag;
    logic                   busy;
    logic [NUM_BR-1:0]      busy_mask;

    modport master (
        output alloc_valid, alloc_rob_tag, res_valid, res_id, res_mispredict,
        input  alloc_ready, alloc_id, dep_mask, resolve, resolve_mask,
               kill, kill_mask, kill_rob_tag, busy, busy_mask
    );

    modport slave (
        input  alloc_valid, alloc_rob_tag, res_valid, res_id, res_mispredict,
        output alloc_ready, alloc_id, dep_mask, resolve, resolve_mask,
               kill, kill_mask, kill_rob_tag, busy, busy_mask
    );
endinterface

// File: rtl/branch_tracker.sv
// Tracks up to NUM_BR outstanding speculative branches: slot allocation,
// relative age, and resolve/squash reporting for pipeline recovery.
module branch_tracker #(
    parameter int unsigned NUM_BR      = 4,
    parameter int unsigned ROB_TAG_LEN = 5,
    parameter int unsigned ID_W        = $clog2(NUM_BR)
) (
    input  logic              clock,
    input  logic              reset,
    branch_tracker_if.slave   bus
);
    logic [NUM_BR-1:0]      valid_q, valid_n;
    logic [ROB_TAG_LEN-1:0] tag_q   [NUM_BR];
    logic [ROB_TAG_LEN-1:0] tag_n   [NUM_BR];
    logic [NUM_BR-1:0]      older_q [NUM_BR];
    logic [NUM_BR-1:0]      older_n [NUM_BR];

    logic                   resolve_q, resolve_n;
    logic [NUM_BR-1:0]      resolve_mask_q, resolve_mask_n;
    logic                   kill_q, kill_n;
    logic [NUM_BR-1:0]      kill_mask_q, kill_mask_n;
    logic [ROB_TAG_LEN-1:0] kill_tag_q, kill_tag_n;

    logic [NUM_BR-1:0]      res_onehot;
    logic [NUM_BR-1:0]      squash_vec;
    logic [NUM_BR-1:0]      clear_mask;
    logic [ROB_TAG_LEN-1:0] res_tag;
    logic                   res_hit, res_ok, res_bad;
    logic                   free_any, grant;
    logic [ID_W-1:0]        free_id;

    // Resolution decode, squash set and lowest-free-slot search
    always_comb begin
        res_onehot = NUM_BR'(1) << bus.res_id;
        res_hit    = bus.res_valid && |(res_onehot & valid_q);
        res_ok     = res_hit && !bus.res_mispredict;
        res_bad    = res_hit && bus.res_mispredict;
        squash_vec = '0;
        res_tag    = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            squash_vec[i] = valid_q[i] && |(older_q[i] & res_onehot);
            if (res_onehot[i]) res_tag = tag_q[i];
        end
        clear_mask = '0;
        if (res_ok)  clear_mask = res_onehot;
        if (res_bad) clear_mask = res_onehot | squash_vec;

        free_any = ~&valid_q;
        free_id  = '0;
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_id = ID_W'(i);
        end
        grant = bus.alloc_valid && free_any && !(bus.res_valid && bus.res_mispredict);
    end

    // Next-state: clear resolved/squashed slots, then install the new branch
    always_comb begin
        valid_n        = valid_q & ~clear_mask;
        resolve_n      = res_ok;
        resolve_mask_n = res_ok ? res_onehot : '0;
        kill_n         = res_bad;
        kill_mask_n    = res_bad ? clear_mask : '0;
        kill_tag_n     = res_bad ? res_tag : '0;
        for (int i = 0; i < NUM_BR; i++) begin
            tag_n[i]   = tag_q[i];
            older_n[i] = older_q[i] & ~clear_mask;
        end
        if (grant) begin
            for (int i = 0; i < NUM_BR; i++) begin
                if (free_id == ID_W'(i)) begin
                    valid_n[i] = 1'b1;
                    tag_n[i]   = bus.alloc_rob_tag;
                    older_n[i] = valid_q & ~clear_mask;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q        <= '0;
            resolve_q      <= 1'b0;
            resolve_mask_q <= '0;
            kill_q         <= 1'b0;
            kill_mask_q    <= '0;
            kill_tag_q     <= '0;
            for (int i = 0; i < NUM_BR; i++) begin
                tag_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_n;
            resolve_q      <= resolve_n;
            resolve_mask_q <= resolve_mask_n;
            kill_q         <= kill_n;
            kill_mask_q    <= kill_mask_n;
            kill_tag_q     <= kill_tag_n;
            for (int i = 0; i < NUM_BR; i++) begin
                tag_q[i]   <= tag_n[i];
                older_q[i] <= older_n[i];
            end
        end
    end

    assign bus.alloc_ready  = free_any && !(bus.res_valid && bus.res_mispredict);
    assign bus.alloc_id     = free_id;
    assign bus.dep_mask     = valid_q;
    assign bus.resolve      = resolve_q;
    assign bus.resolve_mask = resolve_mask_q;
    assign bus.kill         = kill_q;
    assign bus.kill_mask    = kill_mask_q;
    assign bus.kill_rob_tag = kill_tag_q;
    assign bus.busy_mask    = valid_q;
    assign bus.busy         = |valid_q;
endmodule

// File: tb/tb_branch_tracker.sv
// Directed self-checking bench for branch_tracker (NUM_BR=4, ROB_TAG_LEN=5).
module tb_branch_tracker;
    localparam int unsigned NUM_BR      = 4;
    localparam int unsigned ROB_TAG_LEN = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_tracker_if #(.NUM_BR(NUM_BR), .ROB_TAG_LEN(ROB_TAG_LEN)) bif ();

    branch_tracker #(.NUM_BR(NUM_BR), .ROB_TAG_LEN(ROB_TAG_LEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bif.alloc_valid    = 1'b0;
        bif.alloc_rob_tag  = '0;
        bif.res_valid      = 1'b0;
        bif.res_id         = '0;
        bif.res_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_busy_mask", 32'(bif.busy_mask), 32'h0);
        check("rst_kill", 32'(bif.kill), 32'h0);
        cyc();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] tag, input int exp_id);
        bif.alloc_valid   = 1'b1;
        bif.alloc_rob_tag = tag;
        #1;
        check("alloc_ready", 32'(bif.alloc_ready), 32'h1);
        check("alloc_id", 32'(bif.alloc_id), 32'(exp_id));
        cyc();
        bif.alloc_valid = 1'b0;
    endtask

    task automatic res(input int id, input logic mis);
        bif.res_valid      = 1'b1;
        bif.res_id         = 2'(id);
        bif.res_mispredict = mis;
        cyc();
        bif.res_valid      = 1'b0;
        bif.res_mispredict = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #12;
        check("in_reset_busy", 32'(bif.busy), 32'h0);
        reset = 1'b0;
        cyc();

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            check("idle_busy", 32'(bif.busy), 32'h0);
            check("idle_ready", 32'(bif.alloc_ready), 32'h1);
            check("idle_id", 32'(bif.alloc_id), 32'h0);
            check("idle_pulses", 32'({bif.resolve, bif.kill}), 32'h0);
            cyc();
        end

        // Fill all slots
        for (int k = 0; k < 4; k++) alloc(5'(k + 10), k);
        check("full_mask", 32'(bif.busy_mask), 32'hF);
        bif.alloc_valid = 1'b1;
        #1;
        check("full_ready", 32'(bif.alloc_ready), 32'h0);
        cyc();
        bif.alloc_valid = 1'b0;
        check("full_mask_hold", 32'(bif.busy_mask), 32'hF);

        // Out-of-order correct resolve; reallocated slot 1 is younger than 0 and 2
        do_reset();
        alloc(5'd1, 0);
        alloc(5'd2, 1);
        alloc(5'd3, 2);
        check("dep_mask", 32'(bif.dep_mask), 32'h7);
        res(1, 1'b0);
        check("ooo_resolve", 32'(bif.resolve), 32'h1);
        check("ooo_rmask", 32'(bif.resolve_mask), 32'h2);
        check("ooo_busy", 32'(bif.busy_mask), 32'h5);
        check("ooo_nokill", 32'(bif.kill), 32'h0);
        alloc(5'd4, 1);
        check("ooo_pulse_end", 32'(bif.resolve), 32'h0);
        res(2, 1'b1);
        check("ooo_kill", 32'(bif.kill), 32'h1);
        check("ooo_kmask", 32'(bif.kill_mask), 32'h6);
        check("ooo_ktag", 32'(bif.kill_rob_tag), 32'h3);
        check("ooo_kbusy", 32'(bif.busy_mask), 32'h1);

        // Mispredict squashes younger branches
        do_reset();
        alloc(5'd3, 0);
        alloc(5'd7, 1);
        alloc(5'd9, 2);
        res(1, 1'b1);
        check("mp_kill", 32'(bif.kill), 32'h1);
        check("mp_kmask", 32'(bif.kill_mask), 32'h6);
        check("mp_ktag", 32'(bif.kill_rob_tag), 32'h7);
        check("mp_busy", 32'(bif.busy_mask), 32'h1);
        check("mp_noresolve", 32'(bif.resolve), 32'h0);
        cyc();
        check("mp_pulse_end", 32'(bif.kill), 32'h0);

        // Stale resolutions of killed slots are ignored
        res(1, 1'b0);
        check("stale_resolve", 32'(bif.resolve), 32'h0);
        check("stale_busy", 32'(bif.busy_mask), 32'h1);
        res(2, 1'b1);
        check("stale_kill", 32'(bif.kill), 32'h0);
        check("stale_busy2", 32'(bif.busy_mask), 32'h1);

        // Allocation collides with a mispredict on the oldest branch
        alloc(5'd4, 1);
        alloc(5'd5, 2);
        bif.alloc_valid    = 1'b1;
        bif.alloc_rob_tag  = 5'd6;
        bif.res_valid      = 1'b1;
        bif.res_id         = 2'd0;
        bif.res_mispredict = 1'b1;
        #1;
        check("mpcol_ready", 32'(bif.alloc_ready), 32'h0);
        cyc();
        idle_inputs();
        check("mpcol_kmask", 32'(bif.kill_mask), 32'h7);
        check("mpcol_ktag", 32'(bif.kill_rob_tag), 32'h3);
        check("mpcol_busy", 32'(bif.busy_mask), 32'h0);

        // Allocation while full with a correct resolve: granted next cycle
        for (int k = 0; k < 4; k++) alloc(5'(k + 20), k);
        bif.alloc_valid    = 1'b1;
        bif.alloc_rob_tag  = 5'd30;
        bif.res_valid      = 1'b1;
        bif.res_id         = 2'd0;
        bif.res_mispredict = 1'b0;
        #1;
        check("fullres_ready", 32'(bif.alloc_ready), 32'h0);
        cyc();
        bif.res_valid = 1'b0;
        check("fullres_rmask", 32'(bif.resolve_mask), 32'h1);
        check("fullres_busy", 32'(bif.busy_mask), 32'hE);
        #1;
        check("fullres_ready2", 32'(bif.alloc_ready), 32'h1);
        check("fullres_id2", 32'(bif.alloc_id), 32'h0);
        cyc();
        bif.alloc_valid = 1'b0;
        check("fullres_busy2", 32'(bif.busy_mask), 32'hF);
        // Newest branch (slot 0) is youngest: mispredicting slot 3 kills 3 and 0
        res(3, 1'b1);
        check("fullres_kmask", 32'(bif.kill_mask), 32'h9);
        check("fullres_ktag", 32'(bif.kill_rob_tag), 32'd23);

        // Reset mid-run with three busy slots
        do_reset();
        alloc(5'd1, 0);
        alloc(5'd2, 1);
        alloc(5'd3, 2);
        check("mid_busy_pre", 32'(bif.busy_mask), 32'h7);
        reset = 1'b1;
        #2;
        check("mid_busy_mask", 32'(bif.busy_mask), 32'h0);
        check("mid_busy", 32'(bif.busy), 32'h0);
        check("mid_kill", 32'(bif.kill), 32'h0);
        cyc();
        reset = 1'b0;
        cyc();
        check("mid_kill_after", 32'(bif.kill), 32'h0);
        check("mid_ready_after", 32'(bif.alloc_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_tracker.md
# branch_tracker

Tracks up to NUM_BR outstanding speculative branches between dispatch and execute. It is the multi-branch generalisation of the single-branch resolution unit, so the front end no longer stalls on a second branch. It assigns each branch a slot and tracks relative age, then on resolution either frees the slot or reports the mispredicted branch plus every younger branch for squash. Sits between dispatch (allocation) and the branch execute stage (resolution); kill outputs drive ROB/RS/map-table recovery.

## Interface
- NUM_BR, default 4: maximum outstanding branches (2..16).
- ROB_TAG_LEN, default 5: ROB tag width.
- ID_W, default $clog2(NUM_BR): slot index width (derived).

- clock  in  1  system clock; reset is asynchronous, active-high: `reset`; clock: `clock`.
- reset  in  1  async active-high reset.
- alloc_valid  in  1  dispatch presents a branch this cycle.
- alloc_rob_tag  in  ROB_TAG_LEN  ROB tag of the dispatching branch.
- alloc_ready  out  1  slot available and allocation accepted this cycle (combinational).
- alloc_id  out  ID_W  slot granted (lowest free index); meaningful when alloc_ready.
- dep_mask  out  NUM_BR  busy slots before this cycle's updates; tagged onto every dispatching instruction.
- res_valid  in  1  execute resolves a branch.
- res_id  in  ID_W  slot being resolved.
- res_mispredict  in  1  1 = taken (speculation was not-taken, so mispredict); 0 = correct.
- resolve  out  1  registered pulse: correctly predicted branch freed.
- resolve_mask  out  NUM_BR  registered one-hot of freed slot.
- kill  out  1  registered pulse: mispredict recovery.
- kill_mask  out  NUM_BR  registered slots squashed (mispredicted slot plus all younger).
- kill_rob_tag  out  ROB_TAG_LEN  registered ROB tag of the mispredicted branch.
- busy  out  1  any slot outstanding (OR of busy_mask).
- busy_mask  out  NUM_BR  registered slot-occupancy vector.

## Operation
- State per slot i: valid[i], rob_tag[i], older[i] (NUM_BR bits; older[i][j]=1 means slot j is older than slot i).
- Allocation: grant = alloc_valid && alloc_ready. Write valid, rob_tag and older[id] = busy_mask minus any slot freed or killed this cycle.
- alloc_ready = (free slot exists in current busy_mask) && !(res_valid && res_mispredict).
- A slot freed this cycle is not reallocated until the next cycle.
- Correct resolve (res_valid && !res_mispredict && valid[res_id]): clear valid[res_id]; clear column res_id in every older[]; next cycle resolve=1, resolve_mask=onehot(res_id).
- Mispredict (res_valid && res_mispredict && valid[res_id]): K = onehot(res_id) | {i : valid[i] && older[i][res_id]}. Clear valid for all of K and clear the K columns in every older[]. Next cycle kill=1, kill_mask=K, kill_rob_tag=rob_tag[res_id].
- Resolution of a non-valid slot is ignored: no pulse, no state change.
- Simultaneous allocation and correct resolve: both take effect; the new slot's older mask excludes the resolved slot.
- Simultaneous allocation and mispredict: allocation refused (alloc_ready=0); dispatch holds the branch.
- Full (all slots valid): alloc_ready=0; resolution still proceeds.

## Timing
- Reset: valid, older, rob_tag all zero; resolve=0, kill=0, resolve_mask=0, kill_mask=0, kill_rob_tag=0, busy_mask=0, busy=0. alloc_ready=1, alloc_id=0 once reset deasserts.
- Reset mid-operation clears all slots immediately. No kill pulse is generated.
- alloc_ready, alloc_id, dep_mask are combinational from registered state and same-cycle res_*.
- Allocation takes effect at the next edge; busy_mask reflects it one cycle after grant.
- resolve/kill: exactly one cycle high, one cycle after res_valid. Mutually exclusive.
- busy_mask updates on the same edge that raises resolve/kill. Recovery logic sees the slots already cleared.

## Test plan
- Reset then idle: busy=0, alloc_ready=1, alloc_id=0, no pulses for 10 cycles.
- Fill NUM_BR=4: allocate 4 back-to-back → ids 0,1,2,3. busy_mask=4'b1111, alloc_ready=0. A 5th alloc_valid is not granted.
- Out-of-order correct resolve: allocate 0,1,2, then resolve id 1 correct → next cycle resolve=1, resolve_mask=4'b0010, busy_mask=4'b0101. Next alloc gets id 1 and its older mask is {0,2}.
- Mispredict with younger squash: allocate ids 0(tag 3),1(tag 7),2(tag 9), then mispredict id 1 → kill=1, kill_mask=4'b0110, kill_rob_tag=7, busy_mask=4'b0001.
- Simultaneous events: alloc_valid with mispredict on id 0 → alloc_ready=0, kill_mask covers all busy slots. Alloc with correct resolve of id 0 while full → alloc_ready=0 that cycle; granted id 0 the next cycle.
- Stale resolve plus mid-run reset: resolve a killed slot → no pulse, state unchanged. Assert reset with 3 busy slots → busy_mask=0 immediately, kill stays 0.
